// File: rtl/sat_pkg.sv
// sat_pkg: shared constants and types for the SAT backtrack datapath.
//   VAR_NUM / VAR_IDX_W : variable count and index width
//   DEPTH / LEVEL_W     : decision stack depth and occupancy width
//   FREE_ADDR           : variable-table address of the free bitmap
//   decision_entry_t    : one stack entry {var_idx, value, tried}
//   bt_state_t          : backtrack FSM states
package sat_pkg;

    localparam int unsigned VAR_NUM   = 8;
    localparam int unsigned VAR_IDX_W = 3;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned LEVEL_W   = $clog2(DEPTH) + 1;
    localparam logic [1:0]  FREE_ADDR = 2'b01;

    // 'var' is a reserved word, so the variable field is var_idx.
    typedef struct packed {
        logic [VAR_IDX_W-1:0] var_idx;
        logic                 value;
        logic                 tried;
    } decision_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_RD_FREE = 3'd2,
        ST_SET_BIT = 3'd3,
        ST_WR_FREE = 3'd4,
        ST_FLIP    = 3'd5,
        ST_DONE    = 3'd6
    } bt_state_t;

endpackage

// File: rtl/backtrack_engine_if.sv
// backtrack_engine_if: variable-table request/ack port.
//   Handshake: the master raises mem_request with exactly one of
//   mem_read/mem_write, plus mem_address and (for writes) mem_wdata, and
//   holds all of them stable until the slave returns a one-cycle mem_work.
//   Read data on mem_rdata is valid only in the mem_work cycle.
//   master : backtrack_engine side    slave : variable table side
interface backtrack_engine_if;
    import sat_pkg::*;

    logic               mem_request;
    logic               mem_read;
    logic               mem_write;
    logic [1:0]         mem_address;
    logic [VAR_NUM-1:0] mem_wdata;
    logic [VAR_NUM-1:0] mem_rdata;
    logic               mem_work;

    modport master (
        output mem_request, mem_read, mem_write, mem_address, mem_wdata,
        input  mem_rdata, mem_work
    );

    modport slave (
        input  mem_request, mem_read, mem_write, mem_address, mem_wdata,
        output mem_rdata, mem_work
    );

endinterface

// File: rtl/decision_stack.sv
// decision_stack: chronological LIFO of decisions.
//   i_push / i_push_entry     : write entry at top, level+1 (ignored when full)
//   i_pop                     : level-1 (ignored when empty)
//   i_modify / i_modify_entry : overwrite the current top entry
//   o_top                     : current top entry ('0 when empty)
//   o_level / o_full / o_empty: occupancy
// At most one of push/pop/modify is expected per cycle; push has priority.
module decision_stack
    import sat_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_push,
    input  decision_entry_t      i_push_entry,
    input  logic                 i_pop,
    input  logic                 i_modify,
    input  decision_entry_t      i_modify_entry,
    output decision_entry_t      o_top,
    output logic [LEVEL_W-1:0]   o_level,
    output logic                 o_full,
    output logic                 o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    decision_entry_t      r_mem [DEPTH];
    logic [LEVEL_W-1:0]   r_level;
    logic [PTR_W-1:0]     w_top_ptr;
    logic [PTR_W-1:0]     w_push_ptr;
    logic                 w_full;
    logic                 w_empty;

    assign w_full     = (r_level == LEVEL_W'(DEPTH));
    assign w_empty    = (r_level == '0);
    assign w_top_ptr  = PTR_W'(r_level - 1'b1);
    assign w_push_ptr = PTR_W'(r_level);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_level <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push && !w_full) begin
            r_mem[w_push_ptr] <= i_push_entry;
            r_level           <= r_level + 1'b1;
        end else if (i_pop && !w_empty) begin
            r_level <= r_level - 1'b1;
        end else if (i_modify && !w_empty) begin
            r_mem[w_top_ptr] <= i_modify_entry;
        end
    end

    assign o_top   = w_empty ? '0 : r_mem[w_top_ptr];
    assign o_level = r_level;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/backtrack_engine.sv
// backtrack_engine: records decisions and unwinds them on a conflict.
//   clock, reset (async, active-low)
//   push_valid/push_var/push_value : decision taken (accepted in IDLE only)
//   backtrack_req                  : conflict pulse (accepted in IDLE only)
//   mem (master)                   : variable-table port, used to return
//                                    popped variables to the free bitmap
//   flip_valid/var_out/value_out   : flipped decision
//   backtrack_done, unsat, busy, overflow, level : status
//   dbg_state                      : current FSM state
// Every output is a register; control outputs are loaded from the
// next-state decision so they line up with the state they describe.
module backtrack_engine
    import sat_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push_valid,
    input  logic [VAR_IDX_W-1:0]  push_var,
    input  logic                  push_value,
    input  logic                  backtrack_req,
    backtrack_engine_if.master    mem,
    output logic                  flip_valid,
    output logic [VAR_IDX_W-1:0]  var_out,
    output logic                  value_out,
    output logic                  backtrack_done,
    output logic                  unsat,
    output logic                  busy,
    output logic                  overflow,
    output logic [LEVEL_W-1:0]    level,
    output bt_state_t             dbg_state
);

    bt_state_t            r_state;
    bt_state_t            w_next;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_modify;
    decision_entry_t      w_top;
    decision_entry_t      w_push_entry;
    decision_entry_t      w_flip_entry;
    logic                 w_full;
    logic                 w_empty;
    logic [VAR_NUM-1:0]   w_pend_mask;

    logic [VAR_IDX_W-1:0] r_pend_var;
    logic [VAR_NUM-1:0]   r_shadow;
    logic                 r_mem_request;
    logic                 r_mem_read;
    logic                 r_mem_write;
    logic [1:0]           r_mem_address;
    logic [VAR_NUM-1:0]   r_mem_wdata;
    logic                 r_flip_valid;
    logic [VAR_IDX_W-1:0] r_var_out;
    logic                 r_value_out;
    logic                 r_done;
    logic                 r_unsat;
    logic                 r_busy;
    logic                 r_overflow;

    assign w_push_entry = '{var_idx: push_var, value: push_value, tried: 1'b0};
    assign w_flip_entry = '{var_idx: w_top.var_idx, value: ~w_top.value, tried: 1'b1};
    assign w_pend_mask  = VAR_NUM'(1) << r_pend_var;

    decision_stack u_stack (
        .clock          (clock),
        .reset          (reset),
        .i_push         (w_push),
        .i_push_entry   (w_push_entry),
        .i_pop          (w_pop),
        .i_modify       (w_modify),
        .i_modify_entry (w_flip_entry),
        .o_top          (w_top),
        .o_level        (level),
        .o_full         (w_full),
        .o_empty        (w_empty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        w_modify = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A simultaneous conflict wins over the push.
                if (backtrack_req) begin
                    w_next = ST_CHECK;
                end else if (push_valid && !w_full) begin
                    w_push = 1'b1;
                end
            end
            ST_CHECK: begin
                // Once unsat, nothing is unwound any more.
                if (r_unsat || w_empty) begin
                    w_next = ST_DONE;
                end else if (!w_top.tried) begin
                    w_modify = 1'b1;
                    w_next   = ST_FLIP;
                end else begin
                    w_pop  = 1'b1;
                    w_next = ST_RD_FREE;
                end
            end
            ST_RD_FREE: if (mem.mem_work) w_next = ST_SET_BIT;
            ST_SET_BIT: w_next = ST_WR_FREE;
            ST_WR_FREE: if (mem.mem_work) w_next = ST_CHECK;
            ST_FLIP:    w_next = ST_DONE;
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pend_var    <= '0;
            r_shadow      <= '0;
            r_mem_request <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= 2'b00;
            r_mem_wdata   <= '0;
            r_flip_valid  <= 1'b0;
            r_var_out     <= '0;
            r_value_out   <= 1'b0;
            r_done        <= 1'b0;
            r_unsat       <= 1'b0;
            r_busy        <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_mem_request <= (w_next == ST_RD_FREE) || (w_next == ST_WR_FREE);
            r_mem_read    <= (w_next == ST_RD_FREE);
            r_mem_write   <= (w_next == ST_WR_FREE);
            r_mem_address <= ((w_next == ST_RD_FREE) || (w_next == ST_WR_FREE)) ? FREE_ADDR : 2'b00;
            r_flip_valid  <= (w_next == ST_FLIP);
            r_done        <= (w_next == ST_DONE);
            r_busy        <= (w_next != ST_IDLE);

            if (push_valid && w_full) begin
                r_overflow <= 1'b1;
            end
            if ((r_state == ST_CHECK) && w_empty) begin
                r_unsat <= 1'b1;
            end
            if (w_pop) begin
                r_pend_var <= w_top.var_idx;
            end
            if (w_modify) begin
                r_var_out   <= w_flip_entry.var_idx;
                r_value_out <= w_flip_entry.value;
            end
            if ((r_state == ST_RD_FREE) && mem.mem_work) begin
                r_shadow <= mem.mem_rdata;
            end
            // Write data is loaded with the shadow update so it is
            // already correct in the first WR_FREE cycle.
            if (r_state == ST_SET_BIT) begin
                r_shadow    <= r_shadow | w_pend_mask;
                r_mem_wdata <= r_shadow | w_pend_mask;
            end
        end
    end

    assign mem.mem_request = r_mem_request;
    assign mem.mem_read    = r_mem_read;
    assign mem.mem_write   = r_mem_write;
    assign mem.mem_address = r_mem_address;
    assign mem.mem_wdata   = r_mem_wdata;
    assign flip_valid      = r_flip_valid;
    assign var_out         = r_var_out;
    assign value_out       = r_value_out;
    assign backtrack_done  = r_done;
    assign unsat           = r_unsat;
    assign busy            = r_busy;
    assign overflow        = r_overflow;
    assign dbg_state       = r_state;

endmodule

// File: tb/tb_backtrack_engine.sv
// tb_backtrack_engine: directed bench for backtrack_engine with a
// one-cycle-latency variable-table responder and a write scoreboard.
module tb_backtrack_engine;
    import sat_pkg::*;

    logic                 clock;
    logic                 reset;
    logic                 push_valid;
    logic [VAR_IDX_W-1:0] push_var;
    logic                 push_value;
    logic                 backtrack_req;
    logic                 flip_valid;
    logic [VAR_IDX_W-1:0] var_out;
    logic                 value_out;
    logic                 backtrack_done;
    logic                 unsat;
    logic                 busy;
    logic                 overflow;
    logic [LEVEL_W-1:0]   level;
    bt_state_t            dbg_state;

    backtrack_engine_if bus ();

    backtrack_engine dut (
        .clock          (clock),
        .reset          (reset),
        .push_valid     (push_valid),
        .push_var       (push_var),
        .push_value     (push_value),
        .backtrack_req  (backtrack_req),
        .mem            (bus),
        .flip_valid     (flip_valid),
        .var_out        (var_out),
        .value_out      (value_out),
        .backtrack_done (backtrack_done),
        .unsat          (unsat),
        .busy           (busy),
        .overflow       (overflow),
        .level          (level),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;
    int rd_cnt   = 0;
    int wr_cnt   = 0;
    int flip_cnt = 0;
    logic [VAR_IDX_W-1:0] last_var;
    logic                 last_val;
    logic [VAR_NUM-1:0]   rd_data = '0;
    logic                 stall_wr = 1'b0;
    int                   wait_cnt = 0;
    logic [9:0]           exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- variable-table responder + scoreboard ----------------
    initial begin
        bus.mem_work  = 1'b0;
        bus.mem_rdata = '0;
    end

    always @(negedge clock) begin
        if (!reset) begin
            bus.mem_work = 1'b0;
            wait_cnt     = 0;
        end else if (bus.mem_work) begin
            bus.mem_work = 1'b0;
            wait_cnt     = 0;
        end else if (bus.mem_request && !(stall_wr && bus.mem_write)) begin
            if (wait_cnt == 1) begin
                bus.mem_work = 1'b1;
                check("mem_addr", 32'(bus.mem_address), 32'(FREE_ADDR));
                if (bus.mem_read) begin
                    bus.mem_rdata = rd_data;
                    rd_cnt++;
                end
                if (bus.mem_write) begin
                    wr_cnt++;
                    if (exp_q.size() == 0) begin
                        check("wr_unexpected", 32'(exp_q.size()), 32'd1);
                    end else begin
                        check("wr_data", 32'({bus.mem_address, bus.mem_wdata}), 32'(exp_q.pop_front()));
                    end
                end
            end else begin
                wait_cnt++;
            end
        end
    end

    always @(negedge clock) begin
        if (flip_valid) begin
            flip_cnt++;
            last_var = var_out;
            last_val = value_out;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset         = 1'b0;
        push_valid    = 1'b0;
        push_var      = '0;
        push_value    = 1'b0;
        backtrack_req = 1'b0;
        stall_wr      = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic do_push(input int v, input bit val);
        @(negedge clock);
        push_valid = 1'b1;
        push_var   = VAR_IDX_W'(v);
        push_value = val;
        @(negedge clock);
        push_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (backtrack_done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check(tag, 32'(seen), 32'd1);
        @(negedge clock);
    endtask

    task automatic do_backtrack(input string tag);
        @(negedge clock);
        backtrack_req = 1'b1;
        @(negedge clock);
        backtrack_req = 1'b0;
        wait_done(tag);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int f0, r0, w0;
        bit hit;

        do_reset();
        check("rst_level", 32'(level), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_req", 32'(bus.mem_request), 32'd0);
        check("rst_unsat", 32'(unsat), 32'd0);

        // Case 1: untried top flips, fixed latency, no memory traffic.
        do_push(3, 1'b1);
        check("lvl_push1", 32'(level), 32'd1);
        do_push(5, 1'b0);
        check("lvl_push2", 32'(level), 32'd2);
        @(negedge clock);
        backtrack_req = 1'b1;
        @(negedge clock);
        backtrack_req = 1'b0;
        check("lat_check", 32'(dbg_state), 32'(ST_CHECK));
        check("lat_busy", 32'(busy), 32'd1);
        @(negedge clock);
        check("lat_flip", 32'(flip_valid), 32'd1);
        check("c1_var", 32'(var_out), 32'd5);
        check("c1_val", 32'(value_out), 32'd1);
        @(negedge clock);
        check("lat_done", 32'(backtrack_done), 32'd1);
        @(negedge clock);
        check("c1_idle", 32'(busy), 32'd0);
        check("c1_level", 32'(level), 32'd2);
        check("c1_rd", 32'(rd_cnt), 32'd0);
        check("c1_wr", 32'(wr_cnt), 32'd0);

        // Case 2: pop var 5 into the free bitmap, then flip var 3.
        rd_data = 8'b0000_0110;
        exp_q.push_back({2'b01, 8'b0010_0110});
        f0 = flip_cnt;
        do_backtrack("c2_done");
        check("c2_flips", 32'(flip_cnt - f0), 32'd1);
        check("c2_var", 32'(last_var), 32'd3);
        check("c2_val", 32'(last_val), 32'd0);
        check("c2_level", 32'(level), 32'd1);
        check("c2_rd", 32'(rd_cnt), 32'd1);
        check("c2_wr", 32'(wr_cnt), 32'd1);
        check("c2_q", 32'(exp_q.size()), 32'd0);

        // Case 3: pop var 3, stack empties, unsat.
        rd_data = 8'b0010_0110;
        exp_q.push_back({2'b01, 8'b0010_1110});
        f0 = flip_cnt;
        do_backtrack("c3_done");
        check("c3_flips", 32'(flip_cnt - f0), 32'd0);
        check("c3_unsat", 32'(unsat), 32'd1);
        check("c3_level", 32'(level), 32'd0);
        check("c3_wr", 32'(wr_cnt), 32'd2);
        check("c3_q", 32'(exp_q.size()), 32'd0);

        // Case 3b: after unsat, backtrack is CHECK->DONE with no traffic.
        r0 = rd_cnt; w0 = wr_cnt; f0 = flip_cnt;
        do_backtrack("c3b_done");
        check("c3b_rd", 32'(rd_cnt - r0), 32'd0);
        check("c3b_wr", 32'(wr_cnt - w0), 32'd0);
        check("c3b_flips", 32'(flip_cnt - f0), 32'd0);
        check("c3b_unsat", 32'(unsat), 32'd1);

        // Case 4: nine pushes into an eight-deep stack.
        do_reset();
        check("c4_ovf0", 32'(overflow), 32'd0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            push_valid = 1'b1;
            push_var   = VAR_IDX_W'(i);
            push_value = 1'(i);
        end
        @(negedge clock);
        push_valid = 1'b0;
        check("c4_ovf", 32'(overflow), 32'd1);
        check("c4_level", 32'(level), 32'd8);
        do_backtrack("c4_done");
        check("c4_var", 32'(last_var), 32'd7);
        check("c4_val", 32'(last_val), 32'd0);

        // Case 5: push together with backtrack_req -> push dropped.
        do_reset();
        do_push(2, 1'b0);
        r0 = rd_cnt;
        @(negedge clock);
        push_valid    = 1'b1;
        push_var      = 3'd4;
        push_value    = 1'b1;
        backtrack_req = 1'b1;
        @(negedge clock);
        push_valid    = 1'b0;
        backtrack_req = 1'b0;
        wait_done("c5_done");
        check("c5_level", 32'(level), 32'd1);
        check("c5_var", 32'(last_var), 32'd2);
        check("c5_val", 32'(last_val), 32'd1);
        check("c5_rd", 32'(rd_cnt - r0), 32'd0);

        // Case 6: reset while stalled in WR_FREE.
        rd_data  = 8'b0000_0000;
        stall_wr = 1'b1;
        @(negedge clock);
        backtrack_req = 1'b1;
        @(negedge clock);
        backtrack_req = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.mem_write && bus.mem_request) begin
                hit = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("c6_in_wr", 32'(hit), 32'd1);
        check("c6_state", 32'(dbg_state), 32'(ST_WR_FREE));
        #2;
        reset = 1'b0;
        #1;
        check("c6_req", 32'(bus.mem_request), 32'd0);
        check("c6_write", 32'(bus.mem_write), 32'd0);
        check("c6_addr", 32'(bus.mem_address), 32'd0);
        check("c6_wdata", 32'(bus.mem_wdata), 32'd0);
        check("c6_level", 32'(level), 32'd0);
        check("c6_state_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("c6_busy", 32'(busy), 32'd0);
        check("c6_outs", 32'({flip_valid, var_out, value_out, backtrack_done, unsat, overflow}), 32'd0);
        @(negedge clock);
        stall_wr = 1'b0;
        reset    = 1'b1;
        repeat (2) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/backtrack_engine.md
# backtrack_engine

Conflict-side counterpart to the decision engine in the hardware BCP datapath. It records every decision (variable index, polarity) on a chronological LIFO. On a conflict it unwinds that record: it returns exhausted variables to the free bitmap in the variable table, then flips the most recent untried decision. If the stack empties with nothing left to flip, it reports UNSAT. It shares the variable-table request/ack port with the decision engine, which is idle while a backtrack is in progress.

## Interface
- `VAR_NUM`, 8: number of variables; width of the free bitmap.
- `VAR_IDX_W`, 3: width of a variable index, equal to clog2(`VAR_NUM`).
- `DEPTH`, 8: stack entries; must be ≥ `VAR_NUM`.
- `FREE_ADDR`, 2'b01: variable-table address of the free bitmap.

Ports:
- `clock`  in  1  clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low.
- `push_valid`  in  1  one-cycle pulse: a decision was taken.
- `push_var`  in  `VAR_IDX_W`  index of the decided variable.
- `push_value`  in  1  polarity that was assigned.
- `backtrack_req`  in  1  one-cycle pulse: conflict detected.
- `mem_request`  out  1  variable-table access request.
- `mem_read`  out  1  read strobe, qualified by `mem_request`.
- `mem_write`  out  1  write strobe, qualified by `mem_request`.
- `mem_address`  out  2  table address.
- `mem_wdata`  out  `VAR_NUM`  write data.
- `mem_rdata`  in  `VAR_NUM`  read data; valid in the cycle `mem_work`=1.
- `mem_work`  in  1  one-cycle access acknowledge.
- `flip_valid`  out  1  one-cycle pulse: a new assignment is presented.
- `var_out`  out  `VAR_IDX_W`  flipped variable; held until the next flip.
- `value_out`  out  1  new polarity; held until the next flip.
- `backtrack_done`  out  1  one-cycle pulse: backtrack finished.
- `unsat`  out  1  sticky; cleared only by reset.
- `busy`  out  1  state is not IDLE.
- `overflow`  out  1  sticky; set when a push arrives while the stack is full.
- `level`  out  clog2(`DEPTH`)+1  current stack occupancy.

## Operation
- Stack entry: {var, value, tried}. A push writes {push_var, push_value, 0} at the top and increments `level`.
- Pushes are accepted only in IDLE. If a push arrives while `busy`=1, it is dropped.
- If a push arrives in IDLE together with `backtrack_req`, the backtrack wins and the push is dropped.
- If a push arrives while `level`=`DEPTH`, the push is dropped and `overflow` is set.
- State machine:
  - IDLE → CHECK on `backtrack_req`.
  - CHECK, stack empty: set `unsat`, go to DONE.
  - CHECK, top.tried=0: go to FLIP.
  - CHECK, top.tried=1: pop the entry into `pend_var`, decrement `level`, go to RD_FREE.
  - RD_FREE: `mem_request`=1, `mem_read`=1, `mem_address`=`FREE_ADDR`. Wait for `mem_work`; capture `mem_rdata` into the shadow register. Go to SET_BIT.
  - SET_BIT: shadow[`pend_var`] ← 1. Go to WR_FREE.
  - WR_FREE: `mem_request`=1, `mem_write`=1, `mem_address`=`FREE_ADDR`, `mem_wdata`=shadow. Wait for `mem_work`, then go to CHECK.
  - FLIP: top.value ← ~top.value, top.tried ← 1. Drive `var_out`/`value_out` from the updated top and pulse `flip_valid`. Go to DONE.
  - DONE: pulse `backtrack_done`, go to IDLE.
- The flipped variable itself stays non-free; only popped variables are returned to the free bitmap.
- Memory strobes and address are held stable until `mem_work`. All strobes are 0 in every other state.
- A `backtrack_req` arriving while `busy`=1 is ignored.
- Once `unsat`=1, every subsequent `backtrack_req` goes IDLE→CHECK→DONE with no memory traffic.

## Timing
- Reset (asynchronous) values: state IDLE, `level`=0, all stack tried bits 0, every output 0. `mem_address` resets to 2'b00.
- A reset asserted mid-access deasserts `mem_request` immediately; the in-flight access is abandoned.
- All outputs are registered.
- Latency with no pops: `backtrack_req` sampled at edge N → CHECK in cycle N+1 → `flip_valid` in cycle N+2 → `backtrack_done` in cycle N+3.
- Each pop adds RD_FREE (≥1 cycle, ends in the `mem_work` cycle) + SET_BIT (1 cycle) + WR_FREE (≥1 cycle) + the return to CHECK.
- A push is visible in `level` the cycle after `push_valid`.

## Structure
- Package `sat_pkg` holds:
  - `VAR_NUM`, `VAR_IDX_W` and `FREE_ADDR`;
  - the packed typedef `decision_entry_t` {var, value, tried};
  - the enum `bt_state_t`.
- Sub-module `decision_stack`: LIFO with synchronous push, pop and top-modify, plus `level`/full/empty. The FSM, shadow register and memory port stay in `backtrack_engine`.

## Test plan
- Push (3,1), (5,0); backtrack with `mem_work` returned 1 cycle after each request → `flip_valid` with `var_out`=5, `value_out`=1, no memory traffic, `level`=2.
- Continue the previous case: backtrack again with `mem_rdata`=8'b0000_0110 → write of 8'b0010_0110 to address 01, then `flip_valid` with var 3, value 0, `level`=1.
- Backtrack again from there → var 3 returned to free, stack empty, `unsat`=1, `backtrack_done` pulse.
- Push 9 decisions with `DEPTH`=8 → `overflow`=1, `level`=8, top entry is the 8th push.
- `push_valid` and `backtrack_req` in the same IDLE cycle → push dropped, `level` unchanged, backtrack proceeds.
- Reset pulled low during WR_FREE → `mem_request`=0 asynchronously, `level`=0, state IDLE, all outputs 0.
